// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR engine across NUM_CH sample streams.
// One job in flight; per-channel single-entry pending slot with overrun flag.
module fir_channel_scheduler #(
    parameter int  NUM_CH         = 4,
    parameter int  SIGNAL_BITS    = 24,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int CH_BITS        = $clog2(NUM_CH)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_CH-1:0]             sample_valid_i,
    input  logic [NUM_CH*SIGNAL_BITS-1:0] sample_i,
    output logic                          fir_start_o,
    output logic signed [SIGNAL_BITS-1:0] fir_signal_o,
    output logic [CH_BITS-1:0]            fir_chan_o,
    input  logic                          fir_done_i,
    input  logic signed [SIGNAL_BITS-1:0] fir_result_i,
    output logic                          result_valid_o,
    output logic signed [SIGNAL_BITS-1:0] result_o,
    output logic [CH_BITS-1:0]            result_chan_o,
    output logic [NUM_CH-1:0]             overrun_o,
    input  logic                          overrun_clear_i,
    output logic                          timeout_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t state_q;
    state_t state_d;

    logic [SIGNAL_BITS-1:0] data_q [NUM_CH];
    logic [NUM_CH-1:0]      pending_q;
    logic [NUM_CH-1:0]      pending_d;
    logic [NUM_CH-1:0]      overrun_d;
    logic [NUM_CH-1:0]      gnt_vec;
    logic [CH_BITS-1:0]     last_q;
    logic [CH_BITS-1:0]     pick;
    logic [CH_BITS-1:0]     cand;
    logic                   pick_ok;
    logic [15:0]            tmo_cnt_q;
    logic                   grant;
    logic                   take;
    logic                   expire;
    int                     idx;

    // First pending channel after the last grant, wrapping around.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_BITS'(idx);
            if (!pick_ok && pending_q[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        take    = 1'b0;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    grant   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A done on the final permitted cycle still counts.
                if (fir_done_i) begin
                    take    = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    expire  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Granting takes the old sample; a coincident strobe refills the slot.
    always_comb begin
        gnt_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gnt_vec[c] = grant && (pick == CH_BITS'(c));
        end
        pending_d = (pending_q & ~gnt_vec) | sample_valid_i;
        overrun_d = (overrun_o & ~{NUM_CH{overrun_clear_i}})
                  | (sample_valid_i & pending_q & ~gnt_vec);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
            pending_q      <= '0;
            overrun_o      <= '0;
            last_q         <= CH_BITS'(NUM_CH - 1);
            fir_signal_o   <= '0;
            fir_chan_o     <= '0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            result_chan_o  <= '0;
            timeout_o      <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sample_valid_i[c]) begin
                    data_q[c] <= sample_i[c*SIGNAL_BITS +: SIGNAL_BITS];
                end
            end
            pending_q      <= pending_d;
            overrun_o      <= overrun_d;
            result_valid_o <= take;
            timeout_o      <= expire;
            if (grant) begin
                fir_signal_o <= data_q[pick];
                fir_chan_o   <= pick;
                last_q       <= pick;
            end
            if (take) begin
                result_o      <= fir_result_i;
                result_chan_o <= fir_chan_o;
            end
            if (state_q == S_WAIT) tmo_cnt_q <= tmo_cnt_q + 16'd1;
            else                   tmo_cnt_q <= '0;
        end
    end

    assign fir_start_o = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench: timestamp-based job model plus directed literal checks.
module tb_fir_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int SB     = 24;
    localparam int T      = 8;
    localparam int CB     = $clog2(NUM_CH);

    logic                   clk = 1'b0;
    logic                   reset_i = 1'b1;
    logic [NUM_CH-1:0]      sample_valid_i = '0;
    logic [NUM_CH*SB-1:0]   sample_i = '0;
    logic                   fir_start_o;
    logic signed [SB-1:0]   fir_signal_o;
    logic [CB-1:0]          fir_chan_o;
    logic                   fir_done_i = 1'b0;
    logic signed [SB-1:0]   fir_result_i = '0;
    logic                   result_valid_o;
    logic signed [SB-1:0]   result_o;
    logic [CB-1:0]          result_chan_o;
    logic [NUM_CH-1:0]      overrun_o;
    logic                   overrun_clear_i = 1'b0;
    logic                   timeout_o;
    logic                   busy_o;

    fir_channel_scheduler #(
        .NUM_CH(NUM_CH),
        .SIGNAL_BITS(SB),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .sample_valid_i(sample_valid_i),
        .sample_i(sample_i),
        .fir_start_o(fir_start_o),
        .fir_signal_o(fir_signal_o),
        .fir_chan_o(fir_chan_o),
        .fir_done_i(fir_done_i),
        .fir_result_i(fir_result_i),
        .result_valid_o(result_valid_o),
        .result_o(result_o),
        .result_chan_o(result_chan_o),
        .overrun_o(overrun_o),
        .overrun_clear_i(overrun_clear_i),
        .timeout_o(timeout_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each job is a set of timestamps derived at grant time.
    bit              m_pend [NUM_CH];
    int              m_data [NUM_CH];
    logic [NUM_CH-1:0] m_ovr = '0;
    int m_last = NUM_CH - 1;
    int m_free = 0;
    int j_start = -1, j_end = -1, j_done = -1, j_chan = 0;
    bit j_to = 1'b0;
    int m_fsig = 0, m_fchan = 0, m_res = 0, m_rchan = 0;
    int lat_q [$];
    int eng_mode = 0;
    int mg, ml;

    function automatic int pick_lat();
        if (eng_mode > 0) return eng_mode;
        if (eng_mode < 0) return 0;
        if ($urandom_range(0, 9) == 0) return 0;
        return int'($urandom_range(1, T));
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_pend[c] = 1'b0;
                m_data[c] = 0;
            end
            m_ovr = '0; m_last = NUM_CH - 1; m_free = 0;
            j_start = -1; j_end = -1; j_done = -1; j_chan = 0; j_to = 1'b0;
            m_fsig = 0; m_fchan = 0; m_res = 0; m_rchan = 0;
            lat_q.delete();
        end else begin
            if (!j_to && cyc == j_done) begin
                m_res = int'(fir_result_i);
                m_rchan = j_chan;
            end
            mg = -1;
            if (cyc >= m_free) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    if (mg < 0 && m_pend[(m_last + i) % NUM_CH]) mg = (m_last + i) % NUM_CH;
                end
            end
            if (mg >= 0) begin
                ml = pick_lat();
                lat_q.push_back(ml);
                j_start = cyc + 1; j_chan = mg;
                m_fsig = m_data[mg]; m_fchan = mg; m_last = mg;
                if (ml >= 1 && ml <= T) begin
                    j_to = 1'b0; j_done = cyc + 1 + ml; j_end = j_done + 1;
                end else begin
                    j_to = 1'b1; j_done = -1; j_end = cyc + T + 2;
                end
                m_free = j_end;
            end
            if (overrun_clear_i) m_ovr = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sample_valid_i[c]) begin
                    if (m_pend[c] && mg != c) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                    m_data[c] = int'($signed(sample_i[c*SB +: SB]));
                end else if (mg == c) begin
                    m_pend[c] = 1'b0;
                end
            end
        end
        cyc++;
    end

    // Engine stand-in: latency comes from the model's choice for that job.
    int bfm_due = -1, bfm_val = 0, bl = 0, fix_res = 0;
    bit fix_res_en = 1'b0;

    always @(negedge clk) begin
        if (!reset_i && fir_start_o) begin
            bl = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            bfm_due = (bl > 0) ? cyc + bl : -1;
            bfm_val = fix_res_en ? fix_res : int'($signed(SB'($urandom)));
        end
    end

    always @(posedge clk) begin
        #1;
        fir_done_i = (cyc == bfm_due);
        fir_result_i = fir_done_i ? bfm_val[SB-1:0] : SB'($urandom);
    end

    int st_cyc [$], st_chan [$], st_sig [$];
    int rs_cyc [$], rs_chan [$], rs_val [$];
    int to_cyc [$];

    always @(negedge clk) begin
        if (reset_i) begin
            chk("reset_outputs", {fir_start_o, fir_signal_o, fir_chan_o, result_valid_o,
                result_o, result_chan_o, overrun_o, timeout_o, busy_o}, 0);
        end else begin
            chk("fir_start", fir_start_o, cyc == j_start);
            chk("busy", busy_o, cyc >= j_start && cyc < j_end);
            chk("result_valid", result_valid_o, !j_to && cyc == j_end);
            chk("timeout", timeout_o, j_to && cyc == j_end);
            chk("fir_chan", fir_chan_o, m_fchan);
            chk("fir_signal", fir_signal_o, m_fsig);
            chk("result", result_o, m_res);
            chk("result_chan", result_chan_o, m_rchan);
            chk("overrun", overrun_o, m_ovr);
            if (fir_start_o) begin
                st_cyc.push_back(cyc);
                st_chan.push_back(int'(fir_chan_o));
                st_sig.push_back(int'(fir_signal_o));
            end
            if (result_valid_o) begin
                rs_cyc.push_back(cyc);
                rs_chan.push_back(int'(result_chan_o));
                rs_val.push_back(int'(result_o));
            end
            if (timeout_o) to_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sample_valid_i = '0;
            overrun_clear_i = 1'b0;
        end
    endtask

    task automatic put(input int c, input int val);
        sample_valid_i[c] = 1'b1;
        sample_i[c*SB +: SB] = SB'(val);
    endtask

    task automatic clear_logs();
        st_cyc.delete(); st_chan.delete(); st_sig.delete();
        rs_cyc.delete(); rs_chan.delete(); rs_val.delete();
        to_cyc.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick(1);
        clear_logs();
    endtask

    int n;
    int vals [NUM_CH];

    initial begin
        do_reset();

        // Single channel, engine latency 6, fixed result
        eng_mode = 6; fix_res_en = 1'b1; fix_res = 5000;
        n = cyc;
        put(2, -1000);
        tick(13);
        chk("t1_nstart", st_cyc.size(), 1);
        if (st_cyc.size() > 0) begin
            chk("t1_start_cyc", st_cyc[0], n + 2);
            chk("t1_start_chan", st_chan[0], 2);
            chk("t1_start_sig", st_sig[0], -1000);
        end
        chk("t1_nresult", rs_cyc.size(), 1);
        if (rs_cyc.size() > 0) begin
            chk("t1_result", rs_val[0], 5000);
            chk("t1_result_chan", rs_chan[0], 2);
            chk("t1_result_cyc", rs_cyc[0], n + 9);
        end

        // All channels at once, latency 4
        do_reset();
        eng_mode = 4; fix_res_en = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            vals[c] = c * 1000 - 1500;
            put(c, vals[c]);
        end
        tick(31);
        chk("t2_nstart", st_cyc.size(), 4);
        chk("t2_nresult", rs_cyc.size(), 4);
        for (int i = 0; i < NUM_CH; i++) begin
            if (i < st_chan.size()) begin
                chk("t2_start_chan", st_chan[i], i);
                chk("t2_start_sig", st_sig[i], vals[i]);
            end
            if (i < rs_chan.size()) chk("t2_result_chan", rs_chan[i], i);
        end
        if (st_cyc.size() > 1) chk("t2_job_spacing", st_cyc[1] - st_cyc[0], 6);
        chk("t2_no_overrun", overrun_o, 0);

        // Fairness between ch0 and ch3, latency 2
        do_reset();
        eng_mode = 2;
        for (int r = 0; r < 3; r++) begin
            put(0, r + 1);
            put(3, -(r + 1));
            tick(10);
        end
        chk("t3_nstart", st_chan.size(), 6);
        for (int i = 0; i < st_chan.size(); i++) begin
            chk("t3_order", st_chan[i], (i % 2 == 0) ? 0 : 3);
        end

        // Overrun and clear-versus-new-overrun, latency 8
        do_reset();
        eng_mode = 8;
        n = cyc;
        put(0, 7);
        tick(3);
        put(1, 100);
        tick(2);
        put(1, 200);
        tick(1);
        chk("t4_overrun_set", overrun_o, 4'b0010);
        tick(n + 13 - cyc);
        chk("t4_nstart_a", st_chan.size(), 2);
        if (st_chan.size() > 1) begin
            chk("t4_ch1_chan", st_chan[1], 1);
            chk("t4_ch1_sig", st_sig[1], 200);
        end
        overrun_clear_i = 1'b1;
        tick(1);
        chk("t4_clear", overrun_o, 4'b0000);
        put(1, 300);
        tick(1);
        put(1, 400);
        overrun_clear_i = 1'b1;
        tick(1);
        chk("t4_clear_vs_new", overrun_o, 4'b0010);
        tick(25);
        overrun_clear_i = 1'b1;
        tick(1);
        chk("t4_clear_final", overrun_o, 4'b0000);
        chk("t4_nstart_b", st_chan.size(), 3);
        if (st_sig.size() > 2) chk("t4_last_sig", st_sig[2], 400);

        // Timeout: engine never answers
        do_reset();
        eng_mode = -1;
        put(0, 11);
        put(1, 22);
        tick(31);
        chk("t5_ntimeout", to_cyc.size(), 2);
        chk("t5_nresult", rs_cyc.size(), 0);
        chk("t5_nstart", st_cyc.size(), 2);
        if (to_cyc.size() > 0 && st_cyc.size() > 1) begin
            chk("t5_timeout_cyc", to_cyc[0], st_cyc[0] + 9);
            chk("t5_next_start", st_cyc[1], to_cyc[0] + 1);
            chk("t5_next_chan", st_chan[1], 1);
        end

        // Reset during WAIT, stale done after release
        do_reset();
        eng_mode = 6;
        put(2, -5);
        tick(4);
        do_reset();
        tick(4);
        chk("t6_nresult", rs_cyc.size(), 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_result", result_o, 0);
        put(3, 3);
        put(0, 1);
        tick(21);
        chk("t6_nstart", st_chan.size(), 2);
        if (st_chan.size() > 0) chk("t6_first_chan", st_chan[0], 0);

        // Randomized traffic against the model
        do_reset();
        eng_mode = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 99) < 8) put(c, int'($urandom));
            end
            overrun_clear_i = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
